imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 34 +++
 rtl/imem_loader_byte_packer.sv | 50 +++++
 rtl/imem_loader.sv | 137 +++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared definitions for the instruction-memory loader.
//   state_e               : loader FSM states (IDLE, LOAD, WRITE, DONE)
//   IMEM_DEPTH_DEFAULT    : default number of 32-bit words loaded per session
//   word_byte_addr()      : word index -> word-aligned byte address
package imem_loader_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] word_idx);
        return word_idx << 2;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write bus of the loader.
//   byte_valid / byte_data / byte_ready : upstream byte handshake
//   imem_we / imem_addr / imem_wdata    : instruction-memory write port
// Modports:
//   master : the loader (accepts bytes, drives memory writes)
//   slave  : the environment (supplies bytes, receives memory writes)
interface imem_loader_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// byte_packer -- little-endian byte-to-word accumulator for imem_loader.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart packing at byte 0 (session start)
//   byte_fire    : a byte transfers this cycle
//   byte_data    : the byte being transferred
//   word         : accumulator contents including the byte transferring this cycle
//   word_done    : pulse, the 4th byte of a word is being accepted this cycle
module byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_fire,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear) begin
            cnt_d = 2'd0;
            acc_d = '0;
        end else if (byte_fire) begin
            // byte k of the word lands in bits [8k+7:8k]
            acc_d[{cnt_q, 3'b000} +: 8] = byte_data;
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Exposing acc_d lets the loader capture the complete word on the same
    // edge that accepts the 4th byte.
    assign word      = acc_d;
    assign word_done = byte_fire && !clear && (cnt_q == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 2'd0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads DEPTH 32-bit instruction words from a byte stream into
// instruction memory, one word write per four accepted bytes.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : begin a load session (honoured in IDLE and DONE only)
//   bus          : imem_loader_if.master (byte handshake + memory write port)
//   busy         : high in LOAD and WRITE
//   done         : high in DONE
//   checksum     : XOR of all words written this session
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to build the checksum
// register; otherwise checksum is tied to 0.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    imem_loader_if.master       bus,
    output logic                busy,
    output logic                done,
    output logic [31:0]         checksum
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic              imem_we_q, imem_we_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic              packer_clear;
    logic              byte_fire;
    logic [31:0]       packed_word;
    logic              word_done;

    assign bus.byte_ready = (state_q == ST_LOAD);
    assign byte_fire      = bus.byte_valid && bus.byte_ready;

    byte_packer u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (packer_clear),
        .byte_fire (byte_fire),
        .byte_data (bus.byte_data),
        .word      (packed_word),
        .word_done (word_done)
    );

    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        packer_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    word_idx_d   = '0;
                    packer_clear = 1'b1;
                end
            end
            ST_LOAD: begin
                // Address and data are registered on entry to WRITE so they
                // are valid for the whole strobe and hold afterwards.
                if (word_done) begin
                    state_d      = ST_WRITE;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = word_byte_addr(32'(word_idx_q));
                    imem_wdata_d = packed_word;
                end
            end
            ST_WRITE: begin
                if (word_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_LOAD;
                    word_idx_d = word_idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            word_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign busy           = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign done           = (state_q == ST_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (packer_clear) begin
            checksum_d = '0;
        end else if (state_q == ST_WRITE) begin
            checksum_d = checksum_q ^ imem_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int DEPTH = 64;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    imem_loader_if bus ();

    imem_loader #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Writes observed on the memory port, one entry per imem_we cycle.
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            obs_addr.push_back(bus.imem_addr);
            obs_data.push_back(bus.imem_wdata);
        end
    end

    // Reference model state: the words written this session, in order.
    logic [31:0] ref_words[$];

    task automatic check32(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] expected_checksum();
        logic [31:0] x = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        foreach (ref_words[i]) x = x ^ ref_words[i];
`endif
        return x;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check32("byte_ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    // Sends four bytes (byte 0 first) and records the little-endian word they form.
    task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int max_gap);
        ref_words.push_back(32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24));
        send_byte(b0, $urandom_range(0, max_gap));
        send_byte(b1, $urandom_range(0, max_gap));
        send_byte(b2, $urandom_range(0, max_gap));
        send_byte(b3, $urandom_range(0, max_gap));
    endtask

    task automatic wait_writes(input int n);
        int t;
        t = 0;
        while (obs_addr.size() < n && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 100) check32("write_timeout", 32'(obs_addr.size()), 32'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check32({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
        check32({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
        check32({tag, "_imem_addr"},  bus.imem_addr,       32'd0);
        check32({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
        check32({tag, "_busy"},       32'(busy),           32'd0);
        check32({tag, "_done"},       32'(done),           32'd0);
        check32({tag, "_checksum"},   checksum,            32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Reset in the middle of a word
        pulse_start();
        check32("mid_busy_before", 32'(busy), 32'd1);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        check32("mid_reset_no_write", 32'(obs_addr.size()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check32("mid_reset_still_idle", 32'(bus.byte_ready), 32'd0);

        // Single word: bytes 13,00,50,00
        pulse_start();
        ref_words.delete();
        send_word(8'h13, 8'h00, 8'h50, 8'h00, 0);
        wait_writes(1);
        check32("single_count", 32'(obs_addr.size()), 32'd1);
        check32("single_addr",  obs_addr[0], 32'h0000_0000);
        check32("single_data",  obs_data[0], 32'h0050_0013);
        check32("single_we_low_after", 32'(bus.imem_we), 32'd0);
        check32("single_addr_hold",  bus.imem_addr,  32'h0000_0000);
        check32("single_data_hold",  bus.imem_wdata, 32'h0050_0013);
        check32("single_busy", 32'(busy), 32'd1);
        check32("single_done", 32'(done), 32'd0);

        // Rest of the 64-word session with random gaps; start pulsed mid-word
        for (int i = 1; i < DEPTH; i++) begin
            logic [7:0] b0, b1, b2, b3;
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            b3 = 8'($urandom);
            if (i == 20) begin
                ref_words.push_back(32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24));
                send_byte(b0, 1);
                send_byte(b1, 0);
                pulse_start();
                send_byte(b2, 2);
                send_byte(b3, 0);
            end else begin
                send_word(b0, b1, b2, b3, 3);
            end
        end
        wait_writes(DEPTH);
        repeat (2) @(posedge clk);
        #1;
        check32("full_count", 32'(obs_addr.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < obs_addr.size(); i++) begin
            check32($sformatf("full_addr_%0d", i), obs_addr[i], 32'(i * 4));
            check32($sformatf("full_data_%0d", i), obs_data[i], ref_words[i]);
        end
        check32("full_done", 32'(done), 32'd1);
        check32("full_busy", 32'(busy), 32'd0);
        check32("full_byte_ready", 32'(bus.byte_ready), 32'd0);
        check32("full_checksum", checksum, expected_checksum());

        // Restart from DONE with 0x11111111 then 0x22222222
        obs_addr.delete();
        obs_data.delete();
        ref_words.delete();
        pulse_start();
        check32("restart_done", 32'(done), 32'd0);
        check32("restart_busy", 32'(busy), 32'd1);
        check32("restart_checksum_clear", checksum, 32'd0);
        send_word(8'h11, 8'h11, 8'h11, 8'h11, 2);
        wait_writes(1);
        check32("restart_addr0", obs_addr[0], 32'h0000_0000);
        check32("restart_data0", obs_data[0], 32'h1111_1111);
        check32("restart_checksum1", checksum, expected_checksum());
        check32("restart_done_after", 32'(done), 32'd0);
        check32("restart_busy_after", 32'(busy), 32'd1);
        send_word(8'h22, 8'h22, 8'h22, 8'h22, 2);
        wait_writes(2);
        check32("restart_count", 32'(obs_addr.size()), 32'd2);
        check32("restart_addr1", obs_addr[1], 32'h0000_0004);
        check32("restart_data1", obs_data[1], 32'h2222_2222);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check32("restart_checksum2", checksum, 32'h3333_3333);
`else
        check32("restart_checksum2", checksum, 32'h0000_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
